// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg
// Shared constants for alu_pipe and alu_pipe_core:
//   - the mode encodings (arithmetic / logic)
//   - named 4-bit select codes for the logic and arithmetic function tables
package alu_pipe_pkg;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  // Logic-mode select codes
  localparam logic [3:0] SEL_L_NOT_A    = 4'h0;  // ~A
  localparam logic [3:0] SEL_L_NOR      = 4'h1;  // ~(A|B)
  localparam logic [3:0] SEL_L_NA_AND_B = 4'h2;  // ~A&B
  localparam logic [3:0] SEL_L_ZERO     = 4'h3;  // 0
  localparam logic [3:0] SEL_L_NAND     = 4'h4;  // ~(A&B)
  localparam logic [3:0] SEL_L_NOT_B    = 4'h5;  // ~B
  localparam logic [3:0] SEL_L_XOR      = 4'h6;  // A^B
  localparam logic [3:0] SEL_L_A_AND_NB = 4'h7;  // A&~B
  localparam logic [3:0] SEL_L_NA_OR_B  = 4'h8;  // ~A|B
  localparam logic [3:0] SEL_L_XNOR     = 4'h9;  // ~(A^B)
  localparam logic [3:0] SEL_L_B        = 4'hA;  // B
  localparam logic [3:0] SEL_L_AND      = 4'hB;  // A&B
  localparam logic [3:0] SEL_L_ONES     = 4'hC;  // all ones
  localparam logic [3:0] SEL_L_A_OR_NB  = 4'hD;  // A|~B
  localparam logic [3:0] SEL_L_OR       = 4'hE;  // A|B
  localparam logic [3:0] SEL_L_A        = 4'hF;  // A

  // Arithmetic-mode select codes (carry_in is added to each)
  localparam logic [3:0] SEL_A_PASS       = 4'h0;  // A
  localparam logic [3:0] SEL_A_OR         = 4'h1;  // A|B
  localparam logic [3:0] SEL_A_OR_NB      = 4'h2;  // A|~B
  localparam logic [3:0] SEL_A_MINUS_ONE  = 4'h3;  // -1
  localparam logic [3:0] SEL_A_ADD_ANB    = 4'h4;  // A+(A&~B)
  localparam logic [3:0] SEL_A_OR_ADD_ANB = 4'h5;  // (A|B)+(A&~B)
  localparam logic [3:0] SEL_A_SUB_M1     = 4'h6;  // A-B-1
  localparam logic [3:0] SEL_A_ANB_M1     = 4'h7;  // (A&~B)-1
  localparam logic [3:0] SEL_A_ADD_AND    = 4'h8;  // A+(A&B)
  localparam logic [3:0] SEL_A_ADD        = 4'h9;  // A+B
  localparam logic [3:0] SEL_A_ORNB_ADD_AND = 4'hA;  // (A|~B)+(A&B)
  localparam logic [3:0] SEL_A_AND_M1     = 4'hB;  // (A&B)-1
  localparam logic [3:0] SEL_A_DOUBLE     = 4'hC;  // A+A
  localparam logic [3:0] SEL_A_OR_ADD_A   = 4'hD;  // (A|B)+A
  localparam logic [3:0] SEL_A_ORNB_ADD_A = 4'hE;  // (A|~B)+A
  localparam logic [3:0] SEL_A_DEC        = 4'hF;  // A-1

endpackage

// File: rtl/alu_pipe_core.sv
// alu_pipe_core
// Purely combinational ALU function unit (logic and arithmetic tables).
// Ports:
//   mode      in  1      0 = arithmetic, 1 = logic
//   select    in  4      function code
//   carry_in  in  1      added to arithmetic result, ignored in logic mode
//   in_a/in_b in  WIDTH  operands
//   result    out WIDTH  low WIDTH bits of the selected function
//   carry_out out 1      bit WIDTH of the arithmetic sum, 0 in logic mode
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             mode,
  input  logic [3:0]       select,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  logic [WIDTH:0]   a_x, b_x, nb_x, ones_x, arith_base, arith_sum;
  logic [WIDTH-1:0] logic_res;

  // "-1" is the WIDTH-bit all-ones value, so A-B-1 is A + ~B and X-1 is
  // X + all-ones; the carry lands in bit WIDTH of the extended sum.
  always_comb begin
    a_x    = {1'b0, in_a};
    b_x    = {1'b0, in_b};
    nb_x   = {1'b0, ~in_b};
    ones_x = {1'b0, {WIDTH{1'b1}}};

    arith_base = '0;
    case (select)
      SEL_A_PASS:         arith_base = a_x;
      SEL_A_OR:           arith_base = a_x | b_x;
      SEL_A_OR_NB:        arith_base = a_x | nb_x;
      SEL_A_MINUS_ONE:    arith_base = ones_x;
      SEL_A_ADD_ANB:      arith_base = a_x + (a_x & nb_x);
      SEL_A_OR_ADD_ANB:   arith_base = (a_x | b_x) + (a_x & nb_x);
      SEL_A_SUB_M1:       arith_base = a_x + nb_x;
      SEL_A_ANB_M1:       arith_base = (a_x & nb_x) + ones_x;
      SEL_A_ADD_AND:      arith_base = a_x + (a_x & b_x);
      SEL_A_ADD:          arith_base = a_x + b_x;
      SEL_A_ORNB_ADD_AND: arith_base = (a_x | nb_x) + (a_x & b_x);
      SEL_A_AND_M1:       arith_base = (a_x & b_x) + ones_x;
      SEL_A_DOUBLE:       arith_base = a_x + a_x;
      SEL_A_OR_ADD_A:     arith_base = (a_x | b_x) + a_x;
      SEL_A_ORNB_ADD_A:   arith_base = (a_x | nb_x) + a_x;
      default:            arith_base = a_x + ones_x;
    endcase
    arith_sum = arith_base + {{WIDTH{1'b0}}, carry_in};

    logic_res = '0;
    case (select)
      SEL_L_NOT_A:    logic_res = ~in_a;
      SEL_L_NOR:      logic_res = ~(in_a | in_b);
      SEL_L_NA_AND_B: logic_res = ~in_a & in_b;
      SEL_L_ZERO:     logic_res = '0;
      SEL_L_NAND:     logic_res = ~(in_a & in_b);
      SEL_L_NOT_B:    logic_res = ~in_b;
      SEL_L_XOR:      logic_res = in_a ^ in_b;
      SEL_L_A_AND_NB: logic_res = in_a & ~in_b;
      SEL_L_NA_OR_B:  logic_res = ~in_a | in_b;
      SEL_L_XNOR:     logic_res = ~(in_a ^ in_b);
      SEL_L_B:        logic_res = in_b;
      SEL_L_AND:      logic_res = in_a & in_b;
      SEL_L_ONES:     logic_res = '1;
      SEL_L_A_OR_NB:  logic_res = in_a | ~in_b;
      SEL_L_OR:       logic_res = in_a | in_b;
      default:        logic_res = in_a;
    endcase

    if (mode == MODE_LOGIC) begin
      result    = logic_res;
      carry_out = 1'b0;
    end else begin
      result    = arith_sum[WIDTH-1:0];
      carry_out = arith_sum[WIDTH];
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe
// Two-stage valid/ready pipelined ALU. Stage 1 registers the request,
// stage 2 registers the result and flags. OUT_REG=0 bypasses stage 1.
// Optional feature macro: ALU_PIPE_STICKY_EN (adds sticky_clr/sticky_carry).
// Ports:
//   clk, rst (sync, active-high)
//   in_valid/in_ready, mode, select, carry_in, in_a, in_b  request side
//   out_valid/out_ready, alu_out, carry_out, compare, zero   result side
//   sticky_clr in / sticky_carry out                         (macro only)
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned OUT_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ALU_PIPE_STICKY_EN
  input  logic             sticky_clr,
  output logic             sticky_carry,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [3:0]       select,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic             compare,
  output logic             zero
);

  logic             s2_adv;
  logic             s1_valid, s1_mode, s1_cin;
  logic [3:0]       s1_sel;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [WIDTH-1:0] core_res;
  logic             core_cout;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] alu_out_d, alu_out_q;
  logic             carry_d, carry_q, compare_d, compare_q, zero_d, zero_q;

  if (OUT_REG != 0) begin : g_s1
    logic             s1_valid_d, s1_valid_q, s1_mode_d, s1_mode_q;
    logic             s1_cin_d, s1_cin_q;
    logic [3:0]       s1_sel_d, s1_sel_q;
    logic [WIDTH-1:0] s1_a_d, s1_a_q, s1_b_d, s1_b_q;
    logic             s1_ready;

    always_comb begin
      s1_ready   = !s1_valid_q || s2_adv;
      s1_valid_d = s1_valid_q;
      s1_mode_d  = s1_mode_q;
      s1_sel_d   = s1_sel_q;
      s1_cin_d   = s1_cin_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      if (s1_ready) begin
        s1_valid_d = in_valid;
        if (in_valid) begin
          s1_mode_d = mode;
          s1_sel_d  = select;
          s1_cin_d  = carry_in;
          s1_a_d    = in_a;
          s1_b_d    = in_b;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_mode_q  <= 1'b0;
        s1_sel_q   <= '0;
        s1_cin_q   <= 1'b0;
        s1_a_q     <= '0;
        s1_b_q     <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_mode_q  <= s1_mode_d;
        s1_sel_q   <= s1_sel_d;
        s1_cin_q   <= s1_cin_d;
        s1_a_q     <= s1_a_d;
        s1_b_q     <= s1_b_d;
      end
    end

    assign in_ready = s1_ready;
    assign s1_valid = s1_valid_q;
    assign s1_mode  = s1_mode_q;
    assign s1_sel   = s1_sel_q;
    assign s1_cin   = s1_cin_q;
    assign s1_a     = s1_a_q;
    assign s1_b     = s1_b_q;
  end else begin : g_s1_bypass
    // Request feeds the core directly; it is accepted only when stage 2 moves.
    assign in_ready = s2_adv;
    assign s1_valid = in_valid;
    assign s1_mode  = mode;
    assign s1_sel   = select;
    assign s1_cin   = carry_in;
    assign s1_a     = in_a;
    assign s1_b     = in_b;
  end

  alu_pipe_core #(.WIDTH(WIDTH)) u_core (
    .mode      (s1_mode),
    .select    (s1_sel),
    .carry_in  (s1_cin),
    .in_a      (s1_a),
    .in_b      (s1_b),
    .result    (core_res),
    .carry_out (core_cout)
  );

  always_comb begin
    s2_adv      = !out_valid_q || out_ready;
    out_valid_d = out_valid_q;
    alu_out_d   = alu_out_q;
    carry_d     = carry_q;
    compare_d   = compare_q;
    zero_d      = zero_q;
    if (s2_adv) begin
      out_valid_d = s1_valid;
      if (s1_valid) begin
        alu_out_d = core_res;
        carry_d   = core_cout;
        compare_d = &core_res;
        zero_d    = ~|core_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      carry_q     <= 1'b0;
      compare_q   <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      carry_q     <= carry_d;
      compare_q   <= compare_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;
  assign carry_out = carry_q;
  assign compare   = compare_q;
  assign zero      = zero_q;

`ifdef ALU_PIPE_STICKY_EN
  logic sticky_d, sticky_q;

  // Set is applied after clear so a carry emitted during a clear pulse sticks.
  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr) sticky_d = 1'b0;
    if (out_valid_q && out_ready && carry_q) sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign sticky_carry = sticky_q;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, mode, carry_in;
  logic [3:0]  select;
  logic [15:0] in_a, in_b, alu_out;
  logic        out_valid, out_ready, carry_out, compare, zero;
`ifdef ALU_PIPE_STICKY_EN
  logic        sticky_clr, sticky_carry;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [16:0] sb[$];      // expected {carry, result} in emission order
  logic        held;
  logic [15:0] held_val;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(16), .OUT_REG(1)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ALU_PIPE_STICKY_EN
    .sticky_clr   (sticky_clr),
    .sticky_carry (sticky_carry),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .select    (select),
    .carry_in  (carry_in),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .compare   (compare),
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: every "-1" term is worth 2^16-1, arithmetic kept in plain ints.
  function automatic logic [16:0] ref_calc(input logic m, input logic [3:0] s,
                                           input logic c, input logic [15:0] a,
                                           input logic [15:0] b);
    int unsigned A, B, M, NA, NB, r;
    A = a; B = b; M = 32'hFFFF; NA = M - A; NB = M - B;
    r = 0;
    if (m) begin
      case (s)
        4'd0:  r = NA;
        4'd1:  r = M - (A | B);
        4'd2:  r = NA & B;
        4'd3:  r = 0;
        4'd4:  r = M - (A & B);
        4'd5:  r = NB;
        4'd6:  r = A ^ B;
        4'd7:  r = A & NB;
        4'd8:  r = NA | B;
        4'd9:  r = M - (A ^ B);
        4'd10: r = B;
        4'd11: r = A & B;
        4'd12: r = M;
        4'd13: r = A | NB;
        4'd14: r = A | B;
        default: r = A;
      endcase
      return {1'b0, r[15:0]};
    end
    case (s)
      4'd0:  r = A;
      4'd1:  r = A | B;
      4'd2:  r = A | NB;
      4'd3:  r = M;
      4'd4:  r = A + (A & NB);
      4'd5:  r = (A | B) + (A & NB);
      4'd6:  r = A + M - B;
      4'd7:  r = (A & NB) + M;
      4'd8:  r = A + (A & B);
      4'd9:  r = A + B;
      4'd10: r = (A | NB) + (A & B);
      4'd11: r = (A & B) + M;
      4'd12: r = 2 * A;
      4'd13: r = (A | B) + A;
      4'd14: r = (A | NB) + A;
      default: r = A + M;
    endcase
    r = r + c;
    return r[16:0];
  endfunction

  // Observe the cycle set up by the current inputs, then advance one clock.
  task automatic cycle();
    logic [16:0] e;
    #1;
    if (rst) begin
      sb.delete();
      held = 1'b0;
    end else begin
      check("in_ready", in_ready, (sb.size() < 2) || out_ready);
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", alu_out, held_val);
      end
      if (out_valid) check("valid_has_item", sb.size() != 0, 1);
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        check("res", alu_out, e[15:0]);
        check("carry", carry_out, e[16]);
        check("compare", compare, e[15:0] == 16'hFFFF);
        check("zero", zero, e[15:0] == 16'h0000);
      end
      held     = out_valid && !out_ready;
      held_val = alu_out;
      if (in_valid && in_ready) sb.push_back(ref_calc(mode, select, carry_in, in_a, in_b));
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_op(input logic m, input logic [3:0] s, input logic c,
                        input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1; mode = m; select = s; carry_in = c; in_a = a; in_b = b;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0; select = '0;
    carry_in = 1'b0; in_a = '0; in_b = '0; held = 1'b0; held_val = '0;
`ifdef ALU_PIPE_STICKY_EN
    sticky_clr = 1'b0;
`endif
    @(negedge clk); #1;
    cycle(); cycle();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_alu_out", alu_out, 0);
    check("rst_carry", carry_out, 0);
    check("rst_compare", compare, 0);
    check("rst_zero", zero, 0);
    #1 check("rst_in_ready", in_ready, 1);

    // Add with carry-out, latency 2
    out_ready = 1'b1;
    set_op(1'b0, 4'b1001, 1'b0, 16'hFFFF, 16'h0001);
    cycle();
    in_valid = 1'b0;
    check("add_lat1", out_valid, 0);
    cycle();
    check("add_valid", out_valid, 1);
    check("add_res", alu_out, 16'h0000);
    check("add_carry", carry_out, 1);
    check("add_zero", zero, 1);
    cycle();

    // A-B-1 with A=B gives all ones
    set_op(1'b0, 4'b0110, 1'b0, 16'h1234, 16'h1234);
    cycle(); in_valid = 1'b0; cycle();
    check("cmp_res", alu_out, 16'hFFFF);
    check("cmp_flag", compare, 1);
    check("cmp_carry", carry_out, 0);
    cycle();

    // Logic XOR ignores carry_in
    set_op(1'b1, 4'b0110, 1'b1, 16'h00FF, 16'h0F0F);
    cycle(); in_valid = 1'b0; cycle();
    check("xor_res", alu_out, 16'h0FF0);
    check("xor_carry", carry_out, 0);
    cycle();

    // Backpressure: two accepts, then stall
    out_ready = 1'b0;
    set_op(1'b0, 4'b1001, 1'b0, 16'd1, 16'd1); cycle();
    set_op(1'b0, 4'b1001, 1'b0, 16'd2, 16'd1); cycle();
    set_op(1'b0, 4'b1001, 1'b0, 16'd3, 16'd1);
    #1 check("bp_in_ready_low", in_ready, 0);
    cycle();
    check("bp_hold_res", alu_out, 16'h0002);
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("bp_second", alu_out, 16'h0003);
    cycle();
    check("bp_third", alu_out, 16'h0004);
    cycle();
    check("bp_empty", out_valid, 0);

    // Reset with two operations in flight
    out_ready = 1'b0;
    set_op(1'b0, 4'b1001, 1'b0, 16'd5, 16'd1); cycle();
    set_op(1'b0, 4'b1001, 1'b0, 16'd6, 16'd1); cycle();
    in_valid = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_flush_valid", out_valid, 0);
    out_ready = 1'b1;
    set_op(1'b0, 4'b1001, 1'b0, 16'd7, 16'd7); cycle();
    in_valid = 1'b0; cycle();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_res", alu_out, 16'h000E);
    cycle();
    check("post_rst_only_one", out_valid, 0);

`ifdef ALU_PIPE_STICKY_EN
    set_op(1'b0, 4'b1001, 1'b0, 16'hFFFF, 16'h0002); cycle();
    for (int i = 0; i < 3; i++) begin
      set_op(1'b0, 4'b1001, 1'b0, 16'd10, 16'd1); cycle();
    end
    in_valid = 1'b0; cycle(); cycle();
    check("sticky_set", sticky_carry, 1);
    sticky_clr = 1'b1; cycle(); sticky_clr = 1'b0;
    check("sticky_clr", sticky_carry, 0);
`endif

    // Randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      mode      = $urandom_range(0, 1);
      select    = 4'($urandom_range(0, 15));
      carry_in  = $urandom_range(0, 1);
      in_a      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      in_b      = ($urandom_range(0, 7) == 0) ? in_a     : 16'($urandom);
      cycle();
    end

    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) cycle();
    check("drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
- REQ-001: Parameter WIDTH, default 16, is the operand/result width in bits; legal range 4..64.
- REQ-002: Parameter OUT_REG, default 1; 1 registers the result stage (latency 2), 0 makes the compute stage combinational to the output register (latency 1).
- REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-004: rst  input  1  synchronous, active-high reset.
- REQ-005: in_valid  input  1  operation request valid.
- REQ-006: in_ready  output  1  block accepts the request this cycle.
- REQ-007: mode  input  1  0 = arithmetic, 1 = logic.
- REQ-008: select  input  4  function code.
- REQ-009: carry_in  input  1  added to the arithmetic result; ignored in logic mode.
- REQ-010: in_a, in_b  input  WIDTH each  operands.
- REQ-011: out_valid  output  1  result valid.
- REQ-012: out_ready  input  1  downstream accepts the result.
- REQ-013: alu_out  output  WIDTH  result.
- REQ-014: carry_out  output  1  bit WIDTH of the WIDTH+1-bit arithmetic sum; 0 in logic mode.
- REQ-015: compare  output  1  alu_out is all ones.
- REQ-016: zero  output  1  alu_out is all zeros.

Function
- REQ-017: A request transfers when in_valid and in_ready are both high; a result transfers when out_valid and out_ready are both high.
- REQ-018: Logic table (select 0..15): ~A, ~(A|B), ~A&B, 0, ~(A&B), ~B, A^B, A&~B, ~A|B, ~(A^B), B, A&B, all-ones, A|~B, A|B, A.
- REQ-019: Arithmetic table (select 0..15), each plus carry_in: A, A|B, A|~B, -1, A+(A&~B), (A|B)+(A&~B), A-B-1, (A&~B)-1, A+(A&B), A+B, (A|~B)+(A&B), (A&B)-1, A+A, (A|B)+A, (A|~B)+A, A-1.
- REQ-020: Arithmetic is computed at WIDTH+1 bits, with -1 denoting all ones; alu_out is the low WIDTH bits and carry_out is bit WIDTH.
- REQ-021: Stage 1 registers mode, select, carry_in, in_a and in_b; stage 2 registers alu_out and all three flags. With OUT_REG=1, latency from accept to out_valid is 2 cycles.
- REQ-022: Stage 2 advances when !out_valid || out_ready; stage 1 advances into stage 2 when stage 1 is valid and stage 2 advances.
- REQ-023: in_ready = !s1_valid || stage-2-advance; in_ready is combinational from out_ready; sustained throughput is 1 op/cycle.
- REQ-024: Under backpressure the pipeline holds at most 2 operations; results leave in order, with no loss or duplication.
- REQ-025: alu_out and flags stay stable while out_valid && !out_ready.
- REQ-026: A simultaneous accept and emit in one cycle is legal and keeps occupancy constant.

Reset
- REQ-027: On rst, s1_valid, out_valid, alu_out, carry_out, compare and zero become 0 on the next edge; in_ready is 1 in the first cycle after reset.
- REQ-028: Reset mid-operation discards all in-flight operations; no result for them is ever emitted.

Configuration
- REQ-029: Macro ALU_PIPE_STICKY_EN adds input sticky_clr (1 bit) and output sticky_carry (1 bit).
- REQ-030: With ALU_PIPE_STICKY_EN, sticky_carry sets on any emitted result with carry_out=1 and clears on rst or sticky_clr; set wins when set and clear coincide.
- REQ-031: Without ALU_PIPE_STICKY_EN, neither port exists and the remaining behaviour is identical.

Structure
- REQ-032: Package alu_pipe_pkg holds the mode constants (MODE_ARITH=0, MODE_LOGIC=1) and named 4-bit select codes.
- REQ-033: Purely combinational sub-module alu_pipe_core (WIDTH parameter) implements REQ-018..020; alu_pipe holds the pipeline and handshake.

Verification (WIDTH=16, OUT_REG=1)
- REQ-034: Arithmetic add: mode 0, select 1001, A=FFFF, B=0001, cin=0, out_ready=1 -> 2 cycles later out_valid=1, alu_out=0000, carry_out=1, zero=1.
- REQ-035: Compare: mode 0, select 0110, A=B=1234, cin=0 -> alu_out=FFFF, compare=1, carry_out=0.
- REQ-036: Logic: mode 1, select 0110, A=00FF, B=0F0F, cin=1 -> alu_out=0FF0, carry_out=0.
- REQ-037: Backpressure: hold out_ready=0 and offer 3 back-to-back ops (A+B with A=1,2,3, B=1) -> in_ready drops after 2 accepts; releasing out_ready yields 0002, 0003, 0004 in order.
- REQ-038: Reset with 2 ops in flight -> out_valid=0 the next cycle; the first post-reset op emits its own result only.
- REQ-039: Sticky (macro on): one carry-producing op then 3 non-carry ops -> sticky_carry stays 1; sticky_clr pulse -> 0.
